multi_port_memory: RTL and testbench

MULTI_PORT_MEMORY -- requirements
Module: multi_port_memory

---
 rtl/multi_port_memory.sv | 140 ++++++++++++++
 tb/tb_multi_port_memory.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_memory.sv
// Shared single-ported line memory serving NUM_CH requesters through a round-robin
// arbiter; one transaction is in flight at a time and completes LATENCY edges after grant.
module multi_port_memory #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 5,
  parameter int NUM_CH     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH-1:0]              op,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   address,
  input  logic [NUM_CH*LINE_WIDTH-1:0]   data_in,
  output logic [LINE_WIDTH-1:0]          data_out,
  output logic [NUM_CH-1:0]              data_ready,
  output logic                           memory_in_use
);

  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic [CH_W-1:0]        gnt_q, gnt_d;
  logic                   op_q, op_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]  data_out_q;
  logic                   rd_en, wr_en;

  // NOTE: the array is deliberately not reset; its power-up contents come from the
  // declaration initialiser and rst must never touch stored lines.
  logic [LINE_WIDTH-1:0]  mem_q [DEPTH] = '{default: '0};

  logic [ADDR_WIDTH-1:0]  addr_a [NUM_CH];
  logic [LINE_WIDTH-1:0]  din_a  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g] = address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign din_a[g]  = data_in[g*LINE_WIDTH +: LINE_WIDTH];
  end

  // Round-robin search starting at ptr_q (the channel after the last grant).
  logic            found;
  logic [CH_W-1:0] arb_idx;
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic [CH_W-1:0] c;
      c = CH_W'((int'(ptr_q) + k) % NUM_CH);
      if (!found && req[c]) begin
        found   = 1'b1;
        arb_idx = c;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          gnt_d   = arb_idx;
          ptr_d   = (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
          op_d    = op[arb_idx];
          idx_d   = addr_a[arb_idx][OFF +: IDX_W];
          wdata_d = din_a[arb_idx];
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          wr_en   = op_q;
          rd_en   = !op_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      op_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (rd_en) data_out_q <= mem_q[idx_q];
    end
  end

  // A reset landing on the completion edge aborts the write.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[idx_q] <= wdata_q;
  end

  always_comb begin
    data_ready = '0;
    for (int i = 0; i < NUM_CH; i++)
      data_ready[i] = (state_q == DONE) && (gnt_q == CH_W'(i));
  end

  assign data_out      = data_out_q;
  assign memory_in_use = (state_q != IDLE);

endmodule

// File: tb/tb_multi_port_memory.sv
// Directed plus randomised bench for multi_port_memory: a default build checked against
// a line-indexed reference memory, and a LATENCY=1 / 3-channel / 256-bit build.
module tb_multi_port_memory;

  localparam int LW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
  localparam int LAT   = 5;
  localparam int NCH   = 2;

  localparam int LW2    = 256;
  localparam int DEPTH2 = 64;
  localparam int NCH2   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NCH-1:0]      req, op;
  logic [NCH*AW-1:0]   addr_v;
  logic [NCH*LW-1:0]   data_v;
  logic [LW-1:0]       dout;
  logic [NCH-1:0]      dr;
  logic                miu;

  logic [NCH2-1:0]     req2, op2;
  logic [NCH2*AW-1:0]  addr2;
  logic [NCH2*LW2-1:0] data2;
  logic [LW2-1:0]      dout2;
  logic [NCH2-1:0]     dr2;
  logic                miu2;

  multi_port_memory #(
    .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT), .NUM_CH(NCH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .address(addr_v), .data_in(data_v),
    .data_out(dout), .data_ready(dr), .memory_in_use(miu)
  );

  multi_port_memory #(
    .LINE_WIDTH(LW2), .ADDR_WIDTH(AW), .DEPTH(DEPTH2), .LATENCY(1), .NUM_CH(NCH2)
  ) dut2 (
    .clk(clk), .rst(rst), .req(req2), .op(op2), .address(addr2), .data_in(data2),
    .data_out(dout2), .data_ready(dr2), .memory_in_use(miu2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [LW-1:0] model_mem [int];
  logic [LW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] model_rd(input int idx);
    return model_mem.exists(idx) ? model_mem[idx] : '0;
  endfunction

  function automatic int line_of(input logic [AW-1:0] a, input int bytes, input int depth);
    return int'((a / bytes) % depth);
  endfunction

  function automatic int rr_pick(input int mask, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (p + k) % n;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  // One complete transaction on the default build, starting and ending in IDLE.
  task automatic do_txn(input int ch, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, input string tag);
    int n;
    int idx;
    logic [LW-1:0] exp;
    idx = line_of(a, LW / 8, DEPTH);
    req[ch] = 1'b1;
    op[ch]  = wr;
    addr_v[ch*AW +: AW] = a;
    data_v[ch*LW +: LW] = d;
    step();
    check({tag, "_busy"}, miu, 1);
    n = 0;
    while (dr === '0 && n < 4 * LAT) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_ready"}, dr, 1 << ch);
    req[ch] = 1'b0;
    if (wr) begin
      model_mem[idx] = d;
      exp = last_rd;
    end else begin
      exp = model_rd(idx);
      last_rd = exp;
    end
    check({tag, "_dout"}, dout, exp);
    step();
    check({tag, "_idle"}, {dr, miu}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, g, n, pulses, idx;
    logic [AW-1:0] a;
    logic [LW-1:0] d;

    rst = 1'b1;
    req = '0; op = '0; addr_v = '0; data_v = '0;
    req2 = '0; op2 = '0; addr2 = '0; data2 = '0;
    step();
    step();
    check("reset_dut", {dout, dr, miu}, 0);
    check("reset_dut2", {dout2, dr2, miu2}, 0);
    rst = 1'b0;

    // Both channels read from the same cycle and stay requesting: grants alternate from ch0.
    p = 0;
    req = 2'b11;
    addr_v = {32'h10, 32'h0};
    for (int t = 0; t < 4; t++) begin
      n = 0;
      step();
      while (dr === '0 && n < 20) begin
        step();
        n++;
      end
      if (t == 0) check("rr_first_latency", n, LAT);
      g = rr_pick(3, p, NCH);
      p = (g + 1) % NCH;
      check($sformatf("rr_grant%0d", t), dr, 1 << g);
      if (t == 3) req = '0;
    end
    step();
    check("rr_idle", miu, 0);

    do_txn(0, 1'b1, 32'h0, {8{16'h00FF}}, "w_ch0");
    do_txn(0, 1'b0, 32'h0, '0, "r_ch0");
    check("r_ch0_const", dout, {8{16'h00FF}});
    do_txn(1, 1'b1, 32'h10, 128'hDEADBEEF, "w_ch1");
    do_txn(1, 1'b0, 32'h1F, '0, "r_offset");
    check("r_offset_const", dout, 128'hDEADBEEF);
    do_txn(0, 1'b0, 32'(16 * DEPTH), '0, "r_wrap");

    for (int i = 0; i < 24; i++) begin
      a = (AW'($urandom_range(0, 3)) << 16) | (AW'($urandom_range(0, 7)) << 4)
          | AW'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
             $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset two cycles into a write, with a request present at the reset edge.
    a = 32'(200 * 16);
    req[0] = 1'b1; op[0] = 1'b1;
    addr_v[0 +: AW] = a;
    data_v[0 +: LW] = 128'hA5;
    step();
    step();
    rst = 1'b1;
    step();
    check("abort_idle", {dr, miu}, 0);
    rst = 1'b0;
    req = '0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dr !== '0 || miu !== 1'b0) pulses++;
    end
    check("abort_no_activity", pulses, 0);
    do_txn(0, 1'b0, a, '0, "abort_read");

    // Inputs changed and req withdrawn mid-flight: the latched read still completes.
    idx = line_of(32'h10, LW / 8, DEPTH);
    req[0] = 1'b1; op[0] = 1'b0;
    addr_v[0 +: AW] = 32'h10;
    step();
    step();
    addr_v[0 +: AW] = 32'h20;
    op[0] = 1'b1;
    data_v[0 +: LW] = {$urandom, $urandom, $urandom, $urandom};
    req[0] = 1'b0;
    n = 0;
    while (dr === '0 && n < 20) begin
      step();
      n++;
    end
    check("midbusy_ready", dr, 2'b01);
    check("midbusy_dout", dout, model_rd(idx));
    last_rd = model_rd(idx);
    step();
    check("midbusy_single_pulse", {dr, miu}, 0);
    step();
    check("midbusy_stays_idle", miu, 0);
    do_txn(1, 1'b0, 32'h20, '0, "midbusy_no_write");

    // LATENCY=1, three channels all requesting: grants cycle 0,1,2.
    p = 0;
    req2 = 3'b111;
    for (int t = 0; t < 6; t++) begin
      step();
      check($sformatf("l1_busy%0d", t), {dr2, miu2}, 1);
      step();
      g = rr_pick(7, p, NCH2);
      p = (g + 1) % NCH2;
      check($sformatf("l1_grant%0d", t), dr2, 1 << g);
      if (t == 5) req2 = '0;
      step();
    end
    check("l1_idle", miu2, 0);

    for (int t = 0; t < 2; t++) begin
      int ch;
      ch = (t == 0) ? 2 : 1;
      req2[ch] = 1'b1;
      op2[ch]  = (t == 0);
      addr2[ch*AW +: AW] = (t == 0) ? 32'(5 * 32 + 7) : 32'(5 * 32 + DEPTH2 * 32);
      data2[ch*LW2 +: LW2] = {8{32'hC0DE0000 | 32'(t)}};
      step();
      step();
      check($sformatf("l1_wr_rd_ready%0d", t), dr2, 1 << ch);
      req2[ch] = 1'b0;
      if (t == 1) check("l1_rd_dout", dout2, {8{32'hC0DE0000}});
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
